// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receive path.
// Holds the parity-mode encodings, the rx state encoding and the parameter legality check.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  function automatic bit rx_params_ok(input int data_bits, input int clks_per_bit,
                                      input int parity, input int stop_bits,
                                      input int lsb_first);
    return (data_bits >= 5) && (data_bits <= 9) && (clks_per_bit >= 4) &&
           (parity >= PAR_NONE) && (parity <= PAR_ODD) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           ((lsb_first == 0) || (lsb_first == 1));
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RST_VAL sets both flops on reset so an idle line does not look like an edge.
module uart_rx_sync #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with parity/stop checking and a valid/ready output.
// dbg_state mirrors the receive FSM state (rx_state_e encoding) for observation.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int LSB_FIRST    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_parity_err,
  output logic                 out_frame_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  input  logic                 err_clr,
  output logic [2:0]           dbg_state
);

  // Handshake: a word transfers on any clk edge where out_valid && out_ready;
  // out_data and both error flags are held stable while out_valid && !out_ready.

  if (!rx_params_ok(DATA_BITS, CLKS_PER_BIT, PARITY, STOP_BITS, LSB_FIRST)) begin : g_param_check
    $error("uart_rx_param: illegal parameter combination");
  end

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] BAUD_MID  = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD_PAR   = (PARITY == PAR_ODD);

  logic                 rxs;
  rx_state_e            state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 xor_q, xor_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 frame_done;
  logic                 done_ferr;
  logic                 baud_tick;
  logic                 accept;
  logic                 ovr_evt;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  assign baud_tick = (baud_q == BAUD_LAST);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      xor_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      xor_q   <= xor_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    shift_d    = shift_q;
    xor_d      = xor_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;
    done_ferr  = ferr_q;
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          baud_d  = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          xor_d   = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_MID) begin
          baud_d  = '0;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = (LSB_FIRST != 0) ? {rxs, shift_q[DATA_BITS-1:1]}
                                     : {shift_q[DATA_BITS-2:0], rxs};
          xor_d   = xor_q ^ rxs;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          baud_d  = '0;
          // Even parity expects a zero overall XOR, odd parity expects one.
          perr_d  = xor_q ^ rxs ^ ODD_PAR;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          baud_d = '0;
          if (!rxs) ferr_d = 1'b1;
          if (stop_q == STOP_LAST) begin
            frame_done = 1'b1;
            done_ferr  = ferr_q | ~rxs;
            state_d    = rxs ? ST_IDLE : ST_WAIT_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        // A held-low line (break) must not be taken as a fresh start bit.
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept  = frame_done && (!out_valid || out_ready);
  assign ovr_evt = frame_done && out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data       <= '0;
      out_parity_err <= 1'b0;
      out_frame_err  <= 1'b0;
      out_valid      <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (accept) begin
        out_data       <= shift_q;
        out_parity_err <= perr_q;
        out_frame_err  <= done_ferr;
        out_valid      <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (ovr_evt) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three instances cover 8N1, even parity and 7-bit/2-stop/MSB-first.
// Stimulus pushes expected words; per-instance monitors pop and compare on each handshake.
module tb_uart_rx_param;

  localparam int ST_IDLE      = 0;
  localparam int ST_WAIT_IDLE = 5;

  logic       clk;
  logic [2:0] rst_v;
  logic [2:0] rxd_v;
  logic [2:0] rdy_v;
  logic [2:0] clr_v;

  logic [7:0] d0_data, d1_data;
  logic [6:0] d2_data;
  logic       d0_perr, d0_ferr, d0_valid, d0_ovr;
  logic       d1_perr, d1_ferr, d1_valid, d1_ovr;
  logic       d2_perr, d2_ferr, d2_valid, d2_ovr;
  logic [2:0] d0_state, d1_state, d2_state;

  int cpb_tab [3] = '{16, 16, 8};

  logic [10:0] exp_q0[$];
  logic [10:0] exp_q1[$];
  logic [10:0] exp_q2[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t_start  = 0;
  int v0_cnt   = 0;
  bit lat_arm  = 0;

  uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(0), .STOP_BITS(1), .LSB_FIRST(1)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .rxd(rxd_v[0]), .out_data(d0_data), .out_parity_err(d0_perr),
    .out_frame_err(d0_ferr), .out_valid(d0_valid), .out_ready(rdy_v[0]), .overrun(d0_ovr),
    .err_clr(clr_v[0]), .dbg_state(d0_state));

  uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(1), .STOP_BITS(1), .LSB_FIRST(1)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .rxd(rxd_v[1]), .out_data(d1_data), .out_parity_err(d1_perr),
    .out_frame_err(d1_ferr), .out_valid(d1_valid), .out_ready(rdy_v[1]), .overrun(d1_ovr),
    .err_clr(clr_v[1]), .dbg_state(d1_state));

  uart_rx_param #(.DATA_BITS(7), .CLKS_PER_BIT(8), .PARITY(0), .STOP_BITS(2), .LSB_FIRST(0)) u_dut2 (
    .clk(clk), .rst(rst_v[2]), .rxd(rxd_v[2]), .out_data(d2_data), .out_parity_err(d2_perr),
    .out_frame_err(d2_ferr), .out_valid(d2_valid), .out_ready(rdy_v[2]), .overrun(d2_ovr),
    .err_clr(clr_v[2]), .dbg_state(d2_state));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic void push_exp(input int idx, input bit perr, input bit ferr, input logic [8:0] data);
    case (idx)
      0: exp_q0.push_back({perr, ferr, data});
      1: exp_q1.push_back({perr, ferr, data});
      default: exp_q2.push_back({perr, ferr, data});
    endcase
  endfunction

  // scoreboard pop/compare
  function automatic void mon_word(input int idx, input logic [10:0] act);
    logic [10:0] e;
    int sz;
    case (idx)
      0: sz = exp_q0.size();
      1: sz = exp_q1.size();
      default: sz = exp_q2.size();
    endcase
    if (sz == 0) begin
      n_checks++;
      $display("FAIL dut%0d_unexpected_word: got 0x%0h expected no word", idx, act);
    end else begin
      case (idx)
        0: e = exp_q0.pop_front();
        1: e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      chk($sformatf("dut%0d_word", idx), {21'd0, act}, {21'd0, e});
    end
  endfunction

  always @(negedge clk) begin
    if (d0_valid) v0_cnt++;
    if (lat_arm && d0_valid) begin
      lat_arm = 0;
      chk("dut0_latency_cycles", cyc - t_start, 155);
    end
    if (d0_valid && rdy_v[0]) mon_word(0, {d0_perr, d0_ferr, 1'b0, d0_data});
  end

  always @(negedge clk) begin
    if (d1_valid && rdy_v[1]) mon_word(1, {d1_perr, d1_ferr, 1'b0, d1_data});
  end

  always @(negedge clk) begin
    if (d2_valid && rdy_v[2]) mon_word(2, {d2_perr, d2_ferr, 2'b00, d2_data});
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input int idx, input bit val);
    rxd_v[idx] = val;
    step(cpb_tab[idx]);
  endtask

  task automatic send_frame(input int idx, input int nbits, input logic [8:0] data, input bit msb_first,
                            input int npar, input bit par_bit, input int nstop, input bit stop_val);
    if (idx == 0) t_start = cyc;
    drive_bit(idx, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(idx, msb_first ? data[nbits-1-i] : data[i]);
    for (int i = 0; i < npar; i++) drive_bit(idx, par_bit);
    for (int i = 0; i < nstop; i++) drive_bit(idx, stop_val);
  endtask

  initial begin
    rst_v = 3'b111;
    rxd_v = 3'b111;
    rdy_v = 3'b111;
    clr_v = 3'b000;
    step(5);
    rst_v = 3'b000;
    step(2);

    // reset values
    chk("dut0_reset_valid", d0_valid, 0);
    chk("dut0_reset_data", d0_data, 0);
    chk("dut0_reset_flags", {d0_perr, d0_ferr, d0_ovr}, 0);
    chk("dut0_reset_state", d0_state, ST_IDLE);
    chk("dut1_reset_valid", d1_valid, 0);
    chk("dut2_reset_state", d2_state, ST_IDLE);

    // 8N1 word, latency and single-cycle valid pulse
    v0_cnt  = 0;
    lat_arm = 1;
    push_exp(0, 0, 0, 9'h0A5);
    send_frame(0, 8, 9'h0A5, 0, 0, 0, 1, 1);
    step(20);
    chk("dut0_valid_pulse_width", v0_cnt, 1);
    chk("dut0_latency_seen", lat_arm, 0);

    // even parity: wrong then correct parity bit
    push_exp(1, 1, 0, 9'h03C);
    send_frame(1, 8, 9'h03C, 0, 1, 1, 1, 1);
    push_exp(1, 0, 0, 9'h03C);
    send_frame(1, 8, 9'h03C, 0, 1, 0, 1, 1);
    step(20);

    // glitch shorter than half a bit, then back-to-back frames
    rxd_v[0] = 1'b0;
    step(4);
    rxd_v[0] = 1'b1;
    step(30);
    chk("dut0_glitch_state", d0_state, ST_IDLE);
    push_exp(0, 0, 0, 9'h081);
    send_frame(0, 8, 9'h081, 0, 0, 0, 1, 1);
    push_exp(0, 0, 0, 9'h07E);
    send_frame(0, 8, 9'h07E, 0, 0, 0, 1, 1);
    step(20);

    // stop bit low followed by a long break
    push_exp(0, 0, 1, 9'h055);
    send_frame(0, 8, 9'h055, 0, 0, 0, 1, 0);
    step(40 * 16);
    chk("dut0_break_state", d0_state, ST_WAIT_IDLE);
    rxd_v[0] = 1'b1;
    step(6);
    chk("dut0_after_break_state", d0_state, ST_IDLE);

    // back-pressure and overrun
    rdy_v[0] = 1'b0;
    push_exp(0, 0, 0, 9'h011);
    send_frame(0, 8, 9'h011, 0, 0, 0, 1, 1);
    chk("dut0_held_valid", d0_valid, 1);
    chk("dut0_no_overrun_yet", d0_ovr, 0);
    send_frame(0, 8, 9'h022, 0, 0, 0, 1, 1);
    chk("dut0_held_data", d0_data, 8'h11);
    chk("dut0_overrun_set", d0_ovr, 1);
    rdy_v[0] = 1'b1;
    step(2);
    chk("dut0_valid_dropped", d0_valid, 0);
    chk("dut0_overrun_sticky", d0_ovr, 1);
    clr_v[0] = 1'b1;
    step(1);
    clr_v[0] = 1'b0;
    step(1);
    chk("dut0_overrun_cleared", d0_ovr, 0);

    // 7 data bits, 2 stops, MSB first: reset mid-DATA discards the partial frame
    drive_bit(2, 1'b0);
    drive_bit(2, 1'b1);
    drive_bit(2, 1'b0);
    drive_bit(2, 1'b1);
    rst_v[2] = 1'b1;
    step(2);
    rst_v[2] = 1'b0;
    rxd_v[2] = 1'b1;
    step(100);
    chk("dut2_reset_midframe_state", d2_state, ST_IDLE);
    chk("dut2_reset_midframe_valid", d2_valid, 0);
    push_exp(2, 0, 0, 9'h05A);
    send_frame(2, 7, 9'h05A, 1, 0, 0, 2, 1);
    step(20);

    // drain
    for (int i = 0; i < 300; i++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0 && exp_q2.size() == 0) break;
      step(1);
    end
    chk("dut0_queue_drained", exp_q0.size(), 0);
    chk("dut1_queue_drained", exp_q1.size(), 0);
    chk("dut2_queue_drained", exp_q2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
